shout_sweep_ctrl: RTL and testbench
===================================

Name: shout_sweep_ctrl

Overview:
- Sequencer for the loud-box output stage: drives `shout_out` as a square wave whose period sweeps from `HP_START` down to `HP_STOP` in `HP_STEP` decrements.
- Emits a one-cycle `pll_step` strobe at every frequency change so the clock/PLL side can retune.
- After each sweep, holds a silent gap, then repeats while `enable` stays high.
- Sits between the top-level control inputs and the `pll_step`/`shout_out` pads.

Parameters:
- HP_W, 16, width of the half-period counter and `cur_hp`.
- HP_START, 1000, initial half-period in `clk_in` cycles.
- HP_STOP, 200, final half-period. Legal range: 1 <= HP_STOP <= HP_START.
- HP_STEP, 8, half-period decrement per step. Must be >= 1.
- DWELL, 64, full periods emitted at each half-period. Must be >= 1.
- GAP_W, 24, width of the gap counter.
- GAP_CYC, 4096, silent cycles between sweeps. Must be >= 1.

Ports:
- clk_in  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run sweeps continuously, 0 = stop at the next period boundary.
- shout_out  out  1  registered square-wave output.
- pll_step  out  1  registered one-cycle strobe on each half-period change or sweep restart.
- sweep_done  out  1  registered one-cycle strobe when a sweep completes.
- busy  out  1  1 whenever the state is not IDLE.
- cur_hp  out  HP_W  half-period currently in use.

Behaviour:
- Reset (async assert, sync release): state IDLE; shout_out=0, pll_step=0, sweep_done=0, busy=0, cur_hp=HP_START; all counters 0.
- Reset asserted mid-operation returns everything to these values immediately. No pending strobe survives reset.
- States are IDLE, RUN and GAP.
- IDLE:
  - If `enable`=1 is sampled, enter RUN on the next edge with cur_hp=HP_START, hcnt=0, dwell=0, shout_out=0.
  - No strobe is issued on entry from IDLE.
- RUN, half-period counting:
  - hcnt increments every cycle.
  - When hcnt==cur_hp-1: toggle shout_out and clear hcnt.
  - So shout_out is low for cur_hp cycles, then high for cur_hp cycles; a full period is 2*cur_hp cycles.
- RUN, period end (the 1->0 toggle):
  - Each period end increments dwell.
  - At the period end where dwell==DWELL-1, dwell clears and one of these applies:
    - if enable=0, go to IDLE;
    - else if cur_hp==HP_STOP, go to GAP and pulse sweep_done in the same cycle;
    - else set cur_hp = (cur_hp-HP_STOP < HP_STEP) ? HP_STOP : cur_hp-HP_STEP and pulse pll_step in the same cycle.
  - enable=0 at any other period end (dwell not at DWELL-1) also goes to IDLE.
  - shout_out is therefore always low on leaving RUN; there is no partial high phase.
- Clamp rule: the last step lands exactly on HP_STOP. cur_hp never goes below HP_STOP, and no arithmetic underflow is possible.
- GAP:
  - shout_out=0; the gap counter counts GAP_CYC cycles.
  - On the last gap cycle: if enable=1, go to RUN with cur_hp=HP_START and counters cleared, and pulse pll_step (retune to start frequency). Otherwise go to IDLE.
  - enable=0 during GAP does not shorten the gap.
- Simultaneous events: pll_step and sweep_done are never high in the same cycle. Period-end evaluation takes priority over enable changes in that cycle.
- cur_hp holds its value in IDLE. It is reloaded to HP_START only on entry to RUN.

Optional Feature:
- SHOUT_PINGPONG_EN defined:
  - After the dwell at HP_STOP completes, the sweep reverses instead of entering GAP.
  - cur_hp increments by HP_STEP (clamped to HP_START) at each dwell end, with pll_step at every step.
  - sweep_done and entry to GAP occur after the dwell at HP_START completes.
  - A direction register is added; it resets to "down".
- SHOUT_PINGPONG_EN undefined: down-sweep only, exactly as described in Behaviour.

Test Plan (HP_START=8, HP_STOP=4, HP_STEP=2, DWELL=2, GAP_CYC=10 unless noted):
1. Reset release, enable=1 -> RUN one cycle after enable is sampled; shout_out low 8 cycles, then high 8 cycles; busy=1; cur_hp=8.
2. Full sweep -> cur_hp sequence 8,6,4; pll_step pulses exactly 2 times, at RUN-relative cycles 32 and 56; sweep_done at cycle 72; then 10 cycles of silence and a pll_step on RUN re-entry with cur_hp=8.
3. HP_START=9 -> cur_hp sequence 9,7,5,4 (clamped last step); sweep_done only after 2 periods at cur_hp=4.
4. enable dropped mid high-phase at cur_hp=6 -> shout_out completes that high phase, falls, state IDLE next edge; no pll_step or sweep_done; busy=0.
5. rst_n pulsed low during GAP and during a high phase -> all outputs 0 immediately, cur_hp=8; restart behaves as in test 1.
6. SHOUT_PINGPONG_EN defined -> cur_hp sequence 8,6,4,6,8; 4 pll_step pulses; single sweep_done after the final 2 periods at cur_hp=8.

Source files
------------

// File: rtl/shout_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : shout_sweep_ctrl_if
//  Description : Control/status bundle of the shout sweep sequencer. Groups
//                the run request coming from top-level control with the
//                square-wave output, the retune/sweep strobes and the status
//                word going to the pads.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    enable      control -> sequencer  level, 1 = keep sweeping
//    shout_out   sequencer -> pad      registered square wave
//    pll_step    sequencer -> PLL      one-cycle retune strobe
//    sweep_done  sequencer -> control  one-cycle end-of-sweep strobe
//    busy        sequencer -> control  1 while not IDLE
//    cur_hp      sequencer -> control  half-period currently in use
//  Modports
//    master : the controlling side (drives enable, observes the rest)
//    slave  : the sequencer itself
// ============================================================================
interface shout_sweep_ctrl_if #(
   parameter int HP_W = 16
);
   logic            enable;
   logic            shout_out;
   logic            pll_step;
   logic            sweep_done;
   logic            busy;
   logic [HP_W-1:0] cur_hp;

   modport master (
      output enable,
      input  shout_out,
      input  pll_step,
      input  sweep_done,
      input  busy,
      input  cur_hp
   );

   modport slave (
      input  enable,
      output shout_out,
      output pll_step,
      output sweep_done,
      output busy,
      output cur_hp
   );
endinterface : shout_sweep_ctrl_if
`default_nettype wire

// File: rtl/shout_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shout_sweep_ctrl
//  Description : Output-stage sequencer for the loud box. Produces a square
//                wave on shout_out whose half-period sweeps from HP_START
//                down to HP_STOP in HP_STEP decrements, DWELL full periods
//                per half-period, with a one-cycle pll_step strobe at every
//                frequency change. After a sweep a silent gap of GAP_CYC
//                cycles follows, then the sweep repeats while enable is high.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in  in   system clock, rising edge
//    rst_n   in   asynchronous active-low reset; release is expected to be
//                 synchronised to clk_in upstream
//    bus     slave modport of shout_sweep_ctrl_if
//              enable (in), shout_out, pll_step, sweep_done, busy,
//              cur_hp[HP_W-1:0] (out)
//  Optional build macro
//    SHOUT_PINGPONG_EN : when defined, the sweep turns around at HP_STOP and
//                        climbs back to HP_START (clamped) before the gap;
//                        sweep_done fires after the final dwell at HP_START.
//                        Undefined (default): down-sweep only.
// ============================================================================
module shout_sweep_ctrl #(
   parameter int HP_W     = 16,
   parameter int HP_START = 1000,
   parameter int HP_STOP  = 200,
   parameter int HP_STEP  = 8,
   parameter int DWELL    = 64,
   parameter int GAP_W    = 24,
   parameter int GAP_CYC  = 4096
) (
   input  wire logic          clk_in,
   input  wire logic          rst_n,
   shout_sweep_ctrl_if.slave  bus
);

   // Dwell counter only has to reach DWELL-1; keep at least one bit.
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [HP_W-1:0]  c_HP_START   = HP_W'(HP_START);
   localparam logic [HP_W-1:0]  c_HP_STOP    = HP_W'(HP_STOP);
   localparam logic [HP_W-1:0]  c_HP_STEP    = HP_W'(HP_STEP);
   localparam logic [HP_W-1:0]  c_HP_ONE     = HP_W'(1);
   localparam logic [DW_W-1:0]  c_DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0]  c_DW_ONE     = DW_W'(1);
   localparam logic [GAP_W-1:0] c_GAP_LAST   = GAP_W'(GAP_CYC - 1);
   localparam logic [GAP_W-1:0] c_GAP_ONE    = GAP_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           r_state;
   logic [HP_W-1:0]  r_hcnt;
   logic [DW_W-1:0]  r_dwell;
   logic [GAP_W-1:0] r_gcnt;
   logic [HP_W-1:0]  r_cur_hp;
   logic             r_shout;
   logic             r_pll;
   logic             r_done;
   logic             r_busy;

   logic             w_half_end;
   logic             w_dwell_last;
   logic             w_gap_last;
   logic [HP_W-1:0]  w_hp_dn;

   // Last cycle of the current half-period.
   assign w_half_end   = (r_hcnt == (r_cur_hp - c_HP_ONE));
   assign w_dwell_last = (r_dwell == c_DWELL_LAST);
   assign w_gap_last   = (r_gcnt == c_GAP_LAST);

   // Next lower half-period. The distance to HP_STOP is compared first so
   // the subtraction can never wrap and the last step lands on HP_STOP.
   assign w_hp_dn = ((r_cur_hp - c_HP_STOP) < c_HP_STEP) ? c_HP_STOP
                                                         : (r_cur_hp - c_HP_STEP);

`ifdef SHOUT_PINGPONG_EN
   // Sweep direction: 0 = descending, 1 = climbing back to HP_START.
   logic             r_dir_up;
   logic [HP_W-1:0]  w_hp_up;

   // Mirror of w_hp_dn: clamp at HP_START without overflowing.
   assign w_hp_up = ((c_HP_START - r_cur_hp) < c_HP_STEP) ? c_HP_START
                                                          : (r_cur_hp + c_HP_STEP);
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_hcnt   <= '0;
         r_dwell  <= '0;
         r_gcnt   <= '0;
         r_cur_hp <= c_HP_START;
         r_shout  <= 1'b0;
         r_pll    <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
`ifdef SHOUT_PINGPONG_EN
         r_dir_up <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         r_pll  <= 1'b0;
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               // Silent start: no retune strobe when leaving IDLE, the
               // PLL is assumed to already sit at the start frequency.
               if (bus.enable) begin
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
                  r_cur_hp <= c_HP_START;
                  r_hcnt   <= '0;
                  r_dwell  <= '0;
                  r_shout  <= 1'b0;
`ifdef SHOUT_PINGPONG_EN
                  r_dir_up <= 1'b0;
`endif
               end
            end

            S_RUN: begin
               if (!w_half_end) begin
                  r_hcnt <= r_hcnt + c_HP_ONE;
               end else begin
                  r_hcnt  <= '0;
                  r_shout <= ~r_shout;
                  // A high->low toggle closes a full period; only here may
                  // the half-period change or the state be left, so the
                  // output never stops in a partial high phase.
                  if (r_shout) begin
                     if (w_dwell_last) begin
                        r_dwell <= '0;
                     end else begin
                        r_dwell <= r_dwell + c_DW_ONE;
                     end

                     if (!bus.enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_dwell <= '0;
`ifdef SHOUT_PINGPONG_EN
                        r_dir_up <= 1'b0;
`endif
                     end else if (w_dwell_last) begin
`ifdef SHOUT_PINGPONG_EN
                        if (r_dir_up) begin
                           if (r_cur_hp == c_HP_START) begin
                              r_state  <= S_GAP;
                              r_gcnt   <= '0;
                              r_done   <= 1'b1;
                              r_dir_up <= 1'b0;
                           end else begin
                              r_cur_hp <= w_hp_up;
                              r_pll    <= 1'b1;
                           end
                        end else if (r_cur_hp == c_HP_STOP) begin
                           // Turn-around. A zero-width sweep has nothing
                           // to climb back over and ends right here.
                           if (r_cur_hp == c_HP_START) begin
                              r_state <= S_GAP;
                              r_gcnt  <= '0;
                              r_done  <= 1'b1;
                           end else begin
                              r_dir_up <= 1'b1;
                              r_cur_hp <= w_hp_up;
                              r_pll    <= 1'b1;
                           end
                        end else begin
                           r_cur_hp <= w_hp_dn;
                           r_pll    <= 1'b1;
                        end
`else
                        if (r_cur_hp == c_HP_STOP) begin
                           r_state <= S_GAP;
                           r_gcnt  <= '0;
                           r_done  <= 1'b1;
                        end else begin
                           r_cur_hp <= w_hp_dn;
                           r_pll    <= 1'b1;
                        end
`endif
                     end
                  end
               end
            end

            S_GAP: begin
               // The gap always runs to completion; enable is only looked
               // at on its final cycle.
               if (!w_gap_last) begin
                  r_gcnt <= r_gcnt + c_GAP_ONE;
               end else begin
                  r_gcnt <= '0;
                  if (bus.enable) begin
                     // Restart retunes back to the start frequency.
                     r_state  <= S_RUN;
                     r_cur_hp <= c_HP_START;
                     r_hcnt   <= '0;
                     r_dwell  <= '0;
                     r_shout  <= 1'b0;
                     r_pll    <= 1'b1;
`ifdef SHOUT_PINGPONG_EN
                     r_dir_up <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_shout <= 1'b0;
            end
         endcase
      end
   end

   assign bus.shout_out  = r_shout;
   assign bus.pll_step   = r_pll;
   assign bus.sweep_done = r_done;
   assign bus.busy       = r_busy;
   assign bus.cur_hp     = r_cur_hp;

endmodule : shout_sweep_ctrl
`default_nettype wire

// File: tb/tb_shout_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_shout_sweep_ctrl
//  Description : Scoreboard bench for shout_sweep_ctrl. Instance A uses
//                HP_START=8, instance B uses HP_START=9 (clamped last step);
//                both HP_STOP=4, HP_STEP=2, DWELL=2, GAP_CYC=10. Expected
//                strobe events (kind, cur_hp, cycle) are queued when stimulus
//                is issued and checked by a separate negedge monitor.
//                Honours SHOUT_PINGPONG_EN for the expected sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shout_sweep_ctrl;
   localparam int HP_W = 16;
`ifdef SHOUT_PINGPONG_EN
   localparam int A_SWEEP = 128;   // RUN-relative cycle of sweep_done, A
   localparam int B_DONE  = 192;   // RUN-relative cycle of sweep_done, B
`else
   localparam int A_SWEEP = 72;
   localparam int B_DONE  = 100;
`endif

   typedef struct {
      bit              is_done;
      logic [HP_W-1:0] hp;
      int              at;
   } ev_t;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   int   cyc    = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   ev_t  q_a[$];
   ev_t  q_b[$];

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   shout_sweep_ctrl_if #(.HP_W(HP_W)) bus_a ();
   shout_sweep_ctrl_if #(.HP_W(HP_W)) bus_b ();

   shout_sweep_ctrl #(
      .HP_W(HP_W), .HP_START(8), .HP_STOP(4), .HP_STEP(2),
      .DWELL(2), .GAP_W(8), .GAP_CYC(10)
   ) dut_a (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus_a.slave)
   );

   shout_sweep_ctrl #(
      .HP_W(HP_W), .HP_START(9), .HP_STOP(4), .HP_STEP(2),
      .DWELL(2), .GAP_W(8), .GAP_CYC(10)
   ) dut_b (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus_b.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk_in);
   endtask

   function automatic void push_a(input bit d, input int hp, input int at);
      q_a.push_back(ev_t'{d, HP_W'(hp), at});
   endfunction

   function automatic void push_b(input bit d, input int hp, input int at);
      q_b.push_back(ev_t'{d, HP_W'(hp), at});
   endfunction

   // Monitor: every strobe the DUT presents must match the next queued event.
   task automatic mon_ev(input int id, input logic pll, input logic done,
                         input logic [HP_W-1:0] hp);
      ev_t   e;
      string nm;
      nm = (id == 0) ? "A" : "B";
      n_checks++;
      if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
         $display("FAIL strobe_%s: unexpected pll_step=%0d sweep_done=%0d cur_hp=%0d at cycle %0d",
                  nm, pll, done, hp, cyc);
         return;
      end
      if (id == 0) e = q_a.pop_front();
      else         e = q_b.pop_front();
      if (pll && done) begin
         $display("FAIL strobe_%s: pll_step and sweep_done both high at cycle %0d", nm, cyc);
      end else if (done !== e.is_done || hp !== e.hp || cyc != e.at) begin
         $display("FAIL strobe_%s: got done=%0d cur_hp=%0d cycle=%0d, expected done=%0d cur_hp=%0d cycle=%0d",
                  nm, done, hp, cyc, e.is_done, e.hp, e.at);
      end else begin
         n_pass++;
      end
   endtask

   always @(negedge clk_in) begin
      if (bus_a.pll_step || bus_a.sweep_done)
         mon_ev(0, bus_a.pll_step, bus_a.sweep_done, bus_a.cur_hp);
      if (bus_b.pll_step || bus_b.sweep_done)
         mon_ev(1, bus_b.pll_step, bus_b.sweep_done, bus_b.cur_hp);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, r2, t1, t2;
      bus_a.enable = 1'b0;
      bus_b.enable = 1'b0;
      repeat (3) @(negedge clk_in);

      // Reset state
      chk("rst_shout", bus_a.shout_out, 0);
      chk("rst_pll",   bus_a.pll_step, 0);
      chk("rst_done",  bus_a.sweep_done, 0);
      chk("rst_busy",  bus_a.busy, 0);
      chk("rst_hp_a",  bus_a.cur_hp, 8);
      chk("rst_hp_b",  bus_b.cur_hp, 9);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_in);
      chk("idle_busy", bus_a.busy, 0);

      // First sweep on both instances
      bus_a.enable = 1'b1;
      bus_b.enable = 1'b1;
      t0 = cyc + 1;
      push_a(0, 6, t0 + 32);
      push_a(0, 4, t0 + 56);
      push_b(0, 7, t0 + 36);
      push_b(0, 5, t0 + 64);
      push_b(0, 4, t0 + 84);
`ifdef SHOUT_PINGPONG_EN
      push_a(0, 6, t0 + 72);
      push_a(0, 8, t0 + 96);
      push_a(1, 8, t0 + 128);
      push_b(0, 6, t0 + 100);
      push_b(0, 8, t0 + 124);
      push_b(0, 9, t0 + 156);
      push_b(1, 9, t0 + 192);
`else
      push_a(1, 4, t0 + 72);
      push_b(1, 4, t0 + 100);
`endif
      r2 = t0 + A_SWEEP + 10;
      push_a(0, 8, r2);          // retune on re-entry after the gap
      push_a(0, 6, r2 + 32);

      // Instance B: let it finish its sweep, then stop during the gap.
      fork
         begin
            wait_cyc(t0 + B_DONE);
            chk("b_last_hp", bus_b.cur_hp, (B_DONE == 100) ? 4 : 9);
            wait_cyc(t0 + B_DONE + 1);
            bus_b.enable = 1'b0;
            wait_cyc(t0 + B_DONE + 9);
            chk("b_gap_busy", bus_b.busy, 1);
            wait_cyc(t0 + B_DONE + 10);
            chk("b_idle_busy", bus_b.busy, 0);
         end
      join_none

      wait_cyc(t0);
      chk("run0_busy",  bus_a.busy, 1);
      chk("run0_shout", bus_a.shout_out, 0);
      chk("run0_hp",    bus_a.cur_hp, 8);
      wait_cyc(t0 + 7);
      chk("low_last",   bus_a.shout_out, 0);
      wait_cyc(t0 + 8);
      chk("high_first", bus_a.shout_out, 1);
      wait_cyc(t0 + 15);
      chk("high_last",  bus_a.shout_out, 1);
      wait_cyc(t0 + 16);
      chk("low2_first", bus_a.shout_out, 0);
      wait_cyc(t0 + A_SWEEP);
      chk("gap0_shout", bus_a.shout_out, 0);
      chk("gap0_busy",  bus_a.busy, 1);
      wait_cyc(t0 + A_SWEEP + 9);
      chk("gap9_shout", bus_a.shout_out, 0);
      wait_cyc(r2);
      chk("rerun_hp",   bus_a.cur_hp, 8);

      // Drop enable mid high phase at cur_hp=6
      wait_cyc(r2 + 40);
      chk("mid_hp",     bus_a.cur_hp, 6);
      chk("mid_shout",  bus_a.shout_out, 1);
      bus_a.enable = 1'b0;
      wait_cyc(r2 + 43);
      chk("stop_high",  bus_a.shout_out, 1);
      wait_cyc(r2 + 44);
      chk("stop_shout", bus_a.shout_out, 0);
      chk("stop_busy",  bus_a.busy, 0);
      chk("stop_hp",    bus_a.cur_hp, 6);

      // Reset during GAP, then during a high phase
      wait_cyc(t0 + 230);
      bus_a.enable = 1'b1;
      t1 = cyc + 1;
      push_a(0, 6, t1 + 32);
      push_a(0, 4, t1 + 56);
`ifdef SHOUT_PINGPONG_EN
      push_a(0, 6, t1 + 72);
      push_a(0, 8, t1 + 96);
      push_a(1, 8, t1 + 128);
`else
      push_a(1, 4, t1 + 72);
`endif
      wait_cyc(t1 + A_SWEEP + 3);
      chk("gap_busy_pre", bus_a.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rgap_busy",  bus_a.busy, 0);
      chk("rgap_shout", bus_a.shout_out, 0);
      chk("rgap_hp",    bus_a.cur_hp, 8);
      @(negedge clk_in);
      rst_n = 1'b1;
      t2 = cyc + 1;
      wait_cyc(t2);
      chk("rst2_busy",  bus_a.busy, 1);
      chk("rst2_hp",    bus_a.cur_hp, 8);
      wait_cyc(t2 + 8);
      chk("rst2_high",  bus_a.shout_out, 1);
      wait_cyc(t2 + 10);
      rst_n = 1'b0;
      #1;
      chk("rhigh_shout", bus_a.shout_out, 0);
      chk("rhigh_busy",  bus_a.busy, 0);
      chk("rhigh_pll",   bus_a.pll_step, 0);
      bus_a.enable = 1'b0;
      @(negedge clk_in);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_in);
      chk("final_busy", bus_a.busy, 0);
      chk("q_a_empty",  q_a.size(), 0);
      chk("q_b_empty",  q_b.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule : tb_shout_sweep_ctrl
`default_nettype wire
